// File: rtl/tdm_demux_4ch_if.sv
// ----------------------------------------------------------------------------
// tdm_demux_4ch_if
// Bundle of the TDM receiver's serial input and parallel output signals.
//   din, din_valid, frame_sync : serial bit stream from the 4:1 mux transmitter
//   ch0..ch3                   : last complete frame, one WIDTH-bit word per slot
//   frame_valid                : 1-cycle pulse when ch0..ch3 were just updated
//   sync_err                   : 1-cycle pulse on a framing error
//   locked                     : high while the receiver is aligned to frames
// Modports: master = stream source / word consumer, slave = the receiver.
// ----------------------------------------------------------------------------
interface tdm_demux_4ch_if #(
    parameter int WIDTH = 4
) ();
    logic             din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] ch0;
    logic [WIDTH-1:0] ch1;
    logic [WIDTH-1:0] ch2;
    logic [WIDTH-1:0] ch3;
    logic             frame_valid;
    logic             sync_err;
    logic             locked;

    modport master (
        output din, din_valid, frame_sync,
        input  ch0, ch1, ch2, ch3, frame_valid, sync_err, locked
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch0, ch1, ch2, ch3, frame_valid, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux_4ch.sv
// ----------------------------------------------------------------------------
// tdm_demux_4ch
// Receive end of the 4-channel serial TDM link. Frames are 4 slots of WIDTH
// bits, MSB first, slot 0 flagged by frame_sync on its first bit. All four
// words are delivered together once per frame; framing errors are flagged.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : tdm_demux_4ch_if.slave (serial input, parallel words, status)
// ----------------------------------------------------------------------------
module tdm_demux_4ch #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux_4ch_if.slave bus
);
    localparam int FRAME_W = 4 * WIDTH;
    localparam int BIT_W   = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] FIRST_AFTER_SYNC = BIT_W'(1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t             state, state_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [1:0]         slot_cnt, slot_cnt_nxt;
    // Holds all bits of the frame except the final one; the final bit comes
    // straight from din so the words can be loaded on the last strobe.
    logic [FRAME_W-2:0] shift, shift_nxt;
    logic [FRAME_W-1:0] frame_word;
    logic               at_sync_pos;
    logic               load;
    logic               err;

    assign frame_word  = {shift, bus.din};
    assign at_sync_pos = (bit_cnt == '0) && (slot_cnt == 2'd0);
    assign bus.locked  = (state == RUN);

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        slot_cnt_nxt = slot_cnt;
        shift_nxt    = shift;
        load         = 1'b0;
        err          = 1'b0;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        state_nxt    = RUN;
                        bit_cnt_nxt  = FIRST_AFTER_SYNC;
                        slot_cnt_nxt = 2'd0;
                        shift_nxt    = {{(FRAME_W-2){1'b0}}, bus.din};
                    end
                end
                RUN: begin
                    if (bus.frame_sync) begin
                        // Sync anywhere restarts the frame on this bit; only a
                        // sync away from the expected position is an error.
                        err          = !at_sync_pos;
                        bit_cnt_nxt  = FIRST_AFTER_SYNC;
                        slot_cnt_nxt = 2'd0;
                        shift_nxt    = {{(FRAME_W-2){1'b0}}, bus.din};
                    end else if (at_sync_pos) begin
                        // Missing sync: alignment lost, drop the bit.
                        err          = 1'b1;
                        state_nxt    = HUNT;
                        bit_cnt_nxt  = '0;
                        slot_cnt_nxt = 2'd0;
                    end else begin
                        shift_nxt = frame_word[FRAME_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_nxt  = '0;
                            slot_cnt_nxt = slot_cnt + 2'd1;
                            load         = (slot_cnt == 2'd3);
                        end else begin
                            bit_cnt_nxt = bit_cnt + FIRST_AFTER_SYNC;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            slot_cnt <= 2'd0;
            shift    <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            slot_cnt <= slot_cnt_nxt;
            shift    <= shift_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ch0         <= '0;
            bus.ch1         <= '0;
            bus.ch2         <= '0;
            bus.ch3         <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
        end else begin
            bus.frame_valid <= load;
            bus.sync_err    <= err;
            if (load) begin
                bus.ch0 <= frame_word[4*WIDTH-1 -: WIDTH];
                bus.ch1 <= frame_word[3*WIDTH-1 -: WIDTH];
                bus.ch2 <= frame_word[2*WIDTH-1 -: WIDTH];
                bus.ch3 <= frame_word[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux_4ch
// Bench for tdm_demux_4ch (WIDTH=4). A bit-position reference model turns the
// strobe stream into expected frame/error events, queued for a monitor that
// compares them whenever the receiver pulses frame_valid or sync_err. The
// monitor also tracks locked and the held channel words every cycle.
// ----------------------------------------------------------------------------
module tb_tdm_demux_4ch;
    localparam int W  = 4;
    localparam int FW = 4 * W;

    typedef struct {
        bit            is_frame;
        logic [FW-1:0] word;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    ev_t  sbq[$];

    // Reference model state: position within the frame in bits.
    bit            m_locked = 1'b0;
    int            m_pos    = 0;
    logic [FW-1:0] m_acc    = '0;
    logic [FW-1:0] m_ch     = '0;
    // Expectations as seen on the outputs after the most recent edge.
    bit            exp_locked = 1'b0;
    logic [FW-1:0] exp_ch     = '0;

    tdm_demux_4ch_if #(.WIDTH(W)) bus ();

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input bit is_frame, input logic [FW-1:0] word);
        ev_t e;
        e.is_frame = is_frame;
        e.word     = word;
        sbq.push_back(e);
    endtask

    task automatic model_step(input bit s, input bit d);
        if (!m_locked) begin
            if (s) begin
                m_locked = 1'b1;
                m_pos    = 1;
                m_acc    = FW'(d);
            end
        end else if (s) begin
            if (m_pos != 0) push_ev(1'b0, '0);
            m_pos = 1;
            m_acc = FW'(d);
        end else if (m_pos == 0) begin
            push_ev(1'b0, '0);
            m_locked = 1'b0;
        end else begin
            m_acc = {m_acc[FW-2:0], d};
            m_pos++;
            if (m_pos == FW) begin
                push_ev(1'b1, m_acc);
                m_ch  = m_acc;
                m_pos = 0;
            end
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit d);
        bus.din_valid  = v;
        bus.frame_sync = s;
        bus.din        = d;
        if (v) model_step(s, d);
        @(posedge clk);
        #1;
        exp_locked = m_locked;
        exp_ch     = m_ch;
    endtask

    task automatic send_frame(input logic [FW-1:0] word, input bit with_sync, input bit toggle);
        for (int i = 0; i < FW; i++) begin
            if (toggle) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive(1'b1, with_sync && (i == 0), word[FW-1-i]);
        end
    endtask

    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        check("rst_outputs",
              {bus.ch0, bus.ch1, bus.ch2, bus.ch3, bus.frame_valid, bus.sync_err},
              32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        m_locked   = 1'b0;
        m_pos      = 0;
        m_ch       = '0;
        exp_locked = 1'b0;
        exp_ch     = '0;
        sbq.delete();
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        bus.din        = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: consumes expected events when the receiver pulses an output.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.frame_valid || bus.sync_err) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_event: got fv=%0b se=%0b, expected none at %0t",
                                 bus.frame_valid, bus.sync_err, $time);
                    end else begin
                        e = sbq.pop_front();
                        check("event_kind", {30'd0, bus.frame_valid, bus.sync_err},
                              e.is_frame ? 32'd2 : 32'd1);
                        if (e.is_frame)
                            check("frame_words", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'(e.word));
                    end
                end
                check("locked", 32'(bus.locked), 32'(exp_locked));
                check("held_words", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'(exp_ch));
            end
        end
    end

    initial begin
        logic [FW-1:0] w;
        rst            = 1'b1;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        #2;
        check("init_outputs",
              {bus.ch0, bus.ch1, bus.ch2, bus.ch3, bus.frame_valid, bus.sync_err, bus.locked},
              32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame
        send_frame(16'hA6F1, 1'b1, 1'b0);
        check("t2_words", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h0000A6F1);
        check("t2_fv_pulse", 32'(bus.frame_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        check("t2_fv_clear", 32'(bus.frame_valid), 32'd0);

        // Same frame with gaps in the strobe
        send_frame(16'h3C5A, 1'b1, 1'b1);
        check("t3_words", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h00003C5A);
        send_frame(16'hA6F1, 1'b1, 1'b1);
        check("t3_fv_pulse", 32'(bus.frame_valid), 32'd1);

        // Back-to-back, second frame missing sync
        send_frame(16'hA6F1, 1'b1, 1'b0);
        send_frame(16'h1234, 1'b0, 1'b0);
        check("t4_locked", 32'(bus.locked), 32'd0);
        check("t4_words_kept", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h0000A6F1);

        // Early sync at slot 2 bit 1 restarts the frame
        w = 16'hFFFF;
        for (int i = 0; i < 9; i++) drive(1'b1, i == 0, w[FW-1-i]);
        w = 16'h5C3E;
        drive(1'b1, 1'b1, w[FW-1]);
        check("t5_sync_err", 32'(bus.sync_err), 32'd1);
        for (int i = FW - 2; i >= 0; i--) drive(1'b1, 1'b0, w[i]);
        check("t5_words", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h00005C3E);

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 1'b1);
        reset_pulse();

        // Hunting with no sync
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        check("t6_locked", 32'(bus.locked), 32'd0);

        // Randomized stream, syncs mostly where expected
        for (int i = 0; i < 2000; i++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            if (!m_locked || m_pos == 0) s = ($urandom_range(0, 9) != 0);
            else                         s = ($urandom_range(0, 59) == 0);
            drive(v, s, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
        reset_pulse();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);

        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
